// File: rtl/nubus_arb_seq.sv
// -----------------------------------------------------------------------------
// nubus_arb_seq -- NuBus distributed arbitration sequencer for one slot.
//
// Takes a master's level request through the NuBus RQST / ARB contest and
// reports ownership of the bus to the master logic.
//
// Parameters
//   ARB_W       number of ID / ARB lines
//   SETTLE_CYC  clocks the ARB lines must stay unchanged before a decision (1..15)
//   FAIR        1 = after a tenure, hold off requesting until RQST goes idle
//
// Ports
//   nubus_clk   single clock, rising edge
//   nubus_rst   synchronous active-high reset
//   id_n        slot ID, active low (own ID = ~id_n)
//   arb_n       sampled ARB lines, active low
//   start_n     sampled START, active low
//   ack_n       sampled ACK, active low
//   rqst_n      sampled RQST (wired-OR of all requesters), active low
//   req         master wants the bus (level)
//   rel         master ends its tenure (one-cycle pulse); named rel because
//               "release" is a reserved word in SystemVerilog
//   arb_o_n     ARB line drive, active low, 1 = not driven (open collector)
//   rqst_o_n    RQST drive, active low
//   grant       bus owned, master may assert START
//   lost        one-cycle pulse when a contest is lost
// -----------------------------------------------------------------------------
module nubus_arb_seq #(
  parameter int ARB_W      = 4,
  parameter int SETTLE_CYC = 2,
  parameter int FAIR       = 1
) (
  input  logic             nubus_clk,
  input  logic             nubus_rst,
  input  logic [ARB_W-1:0] id_n,
  input  logic [ARB_W-1:0] arb_n,
  input  logic             start_n,
  input  logic             ack_n,
  input  logic             rqst_n,
  input  logic             req,
  input  logic             rel,
  output logic [ARB_W-1:0] arb_o_n,
  output logic             rqst_o_n,
  output logic             grant,
  output logic             lost
);

  localparam int                 CNT_W    = $clog2(SETTLE_CYC + 1);
  localparam logic [CNT_W-1:0]   CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]   SETTLE_V = CNT_W'(SETTLE_CYC);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_RQST      = 3'd1,
    S_ARB       = 3'd2,
    S_WON       = 3'd3,
    S_GRANTED   = 3'd4,
    S_LOST      = 3'd5,
    S_FAIR_HOLD = 3'd6
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [ARB_W-1:0] id;
  logic [ARB_W-1:0] sel;
  logic [ARB_W-1:0] arb_prev;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic             stable;
  logic             decide;
  logic             win;
  logic             tenure;
  logic             lost_q;

  assign id = ~id_n;

  // Standard NuBus self-select: drive our bit only while no higher-order line
  // that we do not own is being pulled low by somebody else.
  always_comb begin
    sel = '0;
    for (int i = 0; i < ARB_W; i++) begin
      sel[i] = id[i];
      for (int j = i + 1; j < ARB_W; j++) begin
        if (!id[j] && !arb_n[j]) sel[i] = 1'b0;
      end
    end
  end

  // Settle counter: counts consecutive cycles with arb_n unchanged against the
  // previous sample; the decision uses the value the counter is about to take.
  assign stable  = (arb_n == arb_prev);
  assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
  assign decide  = stable && (cnt_inc >= SETTLE_V);
  assign win     = (~arb_n == id);

  // State register
  always_ff @(posedge nubus_clk) begin
    if (nubus_rst) state <= S_IDLE;
    else           state <= state_next;
  end

  // Next-state logic; a dropped req aborts any contest phase before anything else
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (req && (id != '0)) state_next = S_RQST;
      end
      S_RQST: begin
        if (!req) state_next = S_IDLE;
        else      state_next = S_ARB;
      end
      S_ARB: begin
        if (!req)        state_next = S_IDLE;
        else if (decide) state_next = win ? S_WON : S_LOST;
      end
      S_WON: begin
        if (!req)         state_next = S_IDLE;
        else if (!tenure) state_next = S_GRANTED;
      end
      S_GRANTED: begin
        // rel wins over req; req alone never ends a tenure
        if (rel) state_next = (FAIR != 0) ? S_FAIR_HOLD : S_IDLE;
      end
      S_LOST: begin
        if (!req)        state_next = S_IDLE;
        else if (!ack_n) state_next = S_ARB;
      end
      S_FAIR_HOLD: begin
        if (rqst_n) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    rqst_o_n = 1'b1;
    grant    = 1'b0;
    arb_o_n  = '1;
    case (state)
      S_RQST: rqst_o_n = 1'b0;
      S_ARB, S_WON, S_LOST: begin
        rqst_o_n = 1'b0;
        arb_o_n  = ~sel;
      end
      S_GRANTED: grant = 1'b1;
      default: ;
    endcase
  end

  assign lost = lost_q;

  // Control registers: settle counter, tenure flag and the lost pulse
  always_ff @(posedge nubus_clk) begin
    if (nubus_rst) begin
      cnt    <= '0;
      tenure <= 1'b0;
      lost_q <= 1'b0;
    end else begin
      // counter only runs while staying in ARB; every entry into ARB starts at 0
      if ((state == S_ARB) && (state_next == S_ARB)) cnt <= stable ? cnt_inc : '0;
      else                                           cnt <= '0;
      // ACK ends a tenure even when START is seen in the same cycle
      if (!ack_n)        tenure <= 1'b0;
      else if (!start_n) tenure <= 1'b1;
      lost_q <= (state == S_ARB) && (state_next == S_LOST);
    end
  end

  // Previous-cycle ARB sample, data only
  always_ff @(posedge nubus_clk) begin
    arb_prev <= arb_n;
  end

endmodule
